// File: rtl/seq_divmod_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   dm_state_t : 2-bit controller state encoding (code 3 unused, decays to IDLE)
package seq_divmod_pkg;

    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_ERROR = 2'd1,
        DM_BUSY  = 2'd2
    } dm_state_t;

endpackage

// File: rtl/seq_divmod_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
// Purely combinational so an unrolled divider can chain WIDTH copies.
//   rem      : partial remainder in (always < dvsr)
//   quo      : dividend/quotient shift register in
//   dvsr     : divisor
//   rem_next : partial remainder out
//   quo_next : quotient shift register out
module seq_divmod_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Keep the remainder MSB: with a divisor above 2^(WIDTH-1) the
        // shifted value can need WIDTH+1 bits before the subtract.
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvsr});
        // Result is < dvsr when it fits, so the low WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - dvsr;
        if (fits) begin
            rem_next = diff;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned restoring divider with go/ready/error handshake.
// A rising edge on go starts a division; one quotient bit is produced per
// cycle and results are held until the next accepted request.
//   clk   : clock, all state updates on posedge
//   rst   : synchronous active-high reset
//   go    : request, 0->1 transition starts an operation
//   a, b  : dividend / divisor, sampled on the accepting edge only
//   ready : 1 = idle with result or error valid
//   error : 1 = last request had b == 0
//   div   : quotient
//   mod   : remainder
module seq_divmod
    import seq_divmod_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] mod
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    dm_state_t        state, state_nx;
    logic             go_prev;
    logic             start;
    logic [CW-1:0]    count, count_nx;
    logic [WIDTH-1:0] dvsr, dvsr_nx;
    logic [WIDTH-1:0] quo, quo_nx;
    logic [WIDTH-1:0] rem, rem_nx;
    logic             ready_nx, error_nx;
    logic [WIDTH-1:0] div_nx, mod_nx;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign start = go && !go_prev;

    seq_divmod_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvsr     (dvsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_nx = state;
        count_nx = count;
        dvsr_nx  = dvsr;
        quo_nx   = quo;
        rem_nx   = rem;
        ready_nx = ready;
        error_nx = error;
        div_nx   = div;
        mod_nx   = mod;

        case (state)
            DM_IDLE, DM_ERROR: ;
            DM_BUSY: begin
                quo_nx   = step_quo;
                rem_nx   = step_rem;
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    div_nx   = step_quo;
                    mod_nx   = step_rem;
                    ready_nx = 1'b1;
                    state_nx = DM_IDLE;
                end
            end
            default: state_nx = DM_IDLE;
        endcase

        // A new request overrides whatever the current state decided,
        // including an operation that is mid-flight or finishing this edge.
        if (start) begin
            if (b == '0) begin
                state_nx = DM_ERROR;
                ready_nx = 1'b1;
                error_nx = 1'b1;
            end else begin
                state_nx = DM_BUSY;
                ready_nx = 1'b0;
                error_nx = 1'b0;
                dvsr_nx  = b;
                quo_nx   = a;
                rem_nx   = '0;
                count_nx = CW'(WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DM_IDLE;
            go_prev <= 1'b0;
            count   <= '0;
            dvsr    <= '0;
            quo     <= '0;
            rem     <= '0;
            ready   <= 1'b1;
            error   <= 1'b0;
            div     <= '0;
            mod     <= '0;
        end else begin
            state   <= state_nx;
            go_prev <= go;
            count   <= count_nx;
            dvsr    <= dvsr_nx;
            quo     <= quo_nx;
            rem     <= rem_nx;
            ready   <= ready_nx;
            error   <= error_nx;
            div     <= div_nx;
            mod     <= mod_nx;
        end
    end

endmodule

// File: tb/tb_seq_divmod.sv
// Scoreboard bench for seq_divmod: stimulus pushes hand-computed results,
// a monitor pops and compares whenever ready or error rises.
module tb_seq_divmod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go  = 1'b0;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic        ready, error;
    logic [15:0] div, mod;

    typedef struct {
        logic        err;
        logic [15:0] d;
        logic [15:0] m;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic [15:0] last_div = '0;
    logic [15:0] last_mod = '0;

    seq_divmod #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .a     (a),
        .b     (b),
        .ready (ready),
        .error (error),
        .div   (div),
        .mod   (mod)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: results are presented when ready or error rises.
    initial begin : monitor
        logic ready_q, error_q;
        exp_t e;
        ready_q = 1'b1;
        error_q = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && ((ready && !ready_q) || (error && !error_q))) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got div=%0d mod=%0d err=%0d expected none",
                             div, mod, error);
                end else begin
                    e = sb.pop_front();
                    check("result_error", int'(error), int'(e.err));
                    check("result_div", int'(div), int'(e.d));
                    check("result_mod", int'(mod), int'(e.m));
                end
            end
            ready_q = ready;
            error_q = error;
        end
    end

    task automatic push_exp(input logic err, input logic [15:0] d, input logic [15:0] m);
        exp_t e;
        e.err = err;
        e.d   = d;
        e.m   = m;
        sb.push_back(e);
        last_div = d;
        last_mod = m;
    endtask

    // Returns 1 time unit after the capture edge, go low, operands scrambled.
    task automatic start_op(input logic [15:0] aa, input logic [15:0] bb);
        @(posedge clk);
        #1;
        a  = aa;
        b  = bb;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        a  = 16'hDEAD;
        b  = 16'h0000;
    endtask

    // Called right after the capture edge: ready low now, low after edge 15,
    // high after edge 16.
    task automatic check_latency(input string tag);
        @(negedge clk);
        check({tag, "_ready_low_at_capture"}, int'(ready), 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_low_edge15"}, int'(ready), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_high_edge16"}, int'(ready), 1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check({tag, "_scoreboard_drained"}, sb.size(), 0);
    endtask

    task automatic divide(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [15:0] d, input logic [15:0] m);
        push_exp(1'b0, d, m);
        start_op(aa, bb);
        check_latency(tag);
        wait_drain(tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int drops;
        logic prev_r;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_ready", int'(ready), 1);
            check("reset_error", int'(error), 0);
            check("reset_div", int'(div), 0);
            check("reset_mod", int'(mod), 0);
        end
        mon_en = 1'b1;

        divide("d100_7", 16'd100, 16'd7, 16'd14, 16'd2);
        divide("d65535_1", 16'd65535, 16'd1, 16'd65535, 16'd0);
        divide("d5_9", 16'd5, 16'd9, 16'd0, 16'd5);
        divide("dmax_max", 16'd65535, 16'd65535, 16'd1, 16'd0);
        divide("dmax_32769", 16'd65535, 16'd32769, 16'd1, 16'd32766);

        // Divide by zero: ready stays high, error rises, results unchanged.
        push_exp(1'b1, last_div, last_mod);
        start_op(16'd42, 16'd0);
        @(negedge clk);
        check("div0_ready_high", int'(ready), 1);
        wait_drain("div0");
        repeat (3) @(negedge clk);
        check("div0_error_persists", int'(error), 1);
        divide("d9_3", 16'd9, 16'd3, 16'd3, 16'd0);

        // go held high: exactly one operation.
        @(posedge clk);
        #1;
        a  = 16'd20;
        b  = 16'd6;
        go = 1'b1;
        push_exp(1'b0, 16'd3, 16'd2);
        drops  = 0;
        prev_r = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!ready && prev_r) drops++;
            prev_r = ready;
        end
        go = 1'b0;
        check("held_go_single_drop", drops, 1);
        check("held_go_ready_end", int'(ready), 1);
        wait_drain("held_go");

        // Restart mid-operation: the first division is discarded.
        start_op(16'd100, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        a  = 16'd50;
        b  = 16'd5;
        go = 1'b1;
        push_exp(1'b0, 16'd10, 16'd0);
        @(posedge clk);
        #1;
        go = 1'b0;
        check_latency("restart");
        wait_drain("restart");

        // Reset mid-operation: abandoned, outputs back to reset values.
        mon_en = 1'b0;
        start_op(16'd100, 16'd7);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(ready), 1);
        check("midrst_error", int'(error), 0);
        check("midrst_div", int'(div), 0);
        check("midrst_mod", int'(mod), 0);
        repeat (20) @(negedge clk);
        check("midrst_ready_stays", int'(ready), 1);
        check("midrst_div_stays", int'(div), 0);
        mon_en = 1'b1;

        divide("d29_5", 16'd29, 16'd5, 16'd5, 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
